mmio_dmem_responder: RTL and testbench

MMIO_DMEM_RESPONDER -- requirements
Module: mmio_dmem_responder

---
 rtl/mmio_dmem_responder.sv | 154 +++++++++++++++
 tb/tb_mmio_dmem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_dmem_responder.sv
// Memory-mapped data-memory responder: a RAM region, a free-running cycle
// counter, and a transmit FIFO with a status register.
// The transmit FIFO is built only when the macro MMIO_TX_FIFO_EN is defined.
// Without it, the tx_* ports and fifo_overflow are tied off and STATUS reads
// as "empty".
module mmio_dmem_responder #(
  parameter int unsigned RAM_AW  = 8,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        fifo_overflow
);

  localparam int unsigned RAM_WORDS   = 1 << RAM_AW;
  localparam logic [11:0] ADDR_CYCLE  = 12'hFF0;
  localparam logic [11:0] ADDR_TXDATA = 12'hFF1;
  localparam logic [11:0] ADDR_STATUS = 12'hFF2;

  logic [31:0]       ram [RAM_WORDS];
  logic [31:0]       cycle;
  logic [31:0]       status_word;
  logic [31:0]       rd_word;
  logic              ram_hit;
  logic [RAM_AW-1:0] ram_idx;

  assign ram_hit = (address_dmem >> RAM_AW) == '0;
  assign ram_idx = address_dmem[RAM_AW-1:0];

  // RAM storage: written on the sampling edge, deliberately not reset.
  always_ff @(posedge clock) begin
    if (wren && ram_hit) begin
      ram[ram_idx] <= data;
    end
  end

  // Free-running cycle counter; a write loads it directly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle <= '0;
    end else if (wren && address_dmem == ADDR_CYCLE) begin
      cycle <= data;
    end else begin
      cycle <= cycle + 32'd1;
    end
  end

  // Read mux. RAM returns pre-write contents; CYCLE returns the value the
  // counter takes at this edge, so a read right after a load sees load+1.
  always_comb begin
    rd_word = '0;
    if (ram_hit) begin
      rd_word = ram[ram_idx];
    end else begin
      case (address_dmem)
        ADDR_CYCLE:  rd_word = cycle + 32'd1;
        ADDR_STATUS: rd_word = status_word;
        default:     rd_word = '0;
      endcase
    end
  end

  // Registered read data, one cycle of latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_dmem <= '0;
    end else begin
      q_dmem <= rd_word;
    end
  end

`ifdef MMIO_TX_FIFO_EN
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  logic [31:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               ovf;

  assign full     = count == CW'(DEPTH);
  assign empty    = count == '0;
  assign push_req = wren && address_dmem == ADDR_TXDATA;
  assign pop      = !empty && tx_ready;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!full || pop);

  assign tx_valid      = !empty;
  assign tx_data       = empty ? '0 : fifo_mem[rd_ptr];
  assign fifo_overflow = ovf;

  // FIFO payload storage; visibility is governed by the pointers and count.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at 2^FIFO_AW.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  // Sticky overflow flag, cleared by writing STATUS with bit 10 set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (wren && address_dmem == ADDR_STATUS && data[10]) begin
      ovf <= 1'b0;
    end else if (push_req && !push_ok) begin
      ovf <= 1'b1;
    end
  end

  // STATUS word assembly.
  always_comb begin
    status_word            = '0;
    status_word[FIFO_AW:0] = count;
    status_word[8]         = full;
    status_word[9]         = empty;
    status_word[10]        = ovf;
  end
`else
  logic unused_fifo;

  assign unused_fifo   = tx_ready ^ (FIFO_AW == 0);
  assign tx_valid      = 1'b0;
  assign tx_data       = '0;
  assign fifo_overflow = 1'b0;
  assign status_word   = 32'h0000_0200;
`endif

endmodule

// File: tb/tb_mmio_dmem_responder.sv
// Self-checking bench for mmio_dmem_responder against a queue-based model.
module tb_mmio_dmem_responder;
  localparam int unsigned RAM_AW  = 8;
  localparam int unsigned FIFO_AW = 2;
  localparam int unsigned DEPTH   = 1 << FIFO_AW;
`ifdef MMIO_TX_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] address_dmem = 12'h800;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] q_dmem;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        fifo_overflow;

  always #5 clock = ~clock;

  mmio_dmem_responder #(.RAM_AW(RAM_AW), .FIFO_AW(FIFO_AW)) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
    .wren(wren), .q_dmem(q_dmem), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .fifo_overflow(fifo_overflow)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [31:0] m_cycle = '0;
  logic [31:0] m_fifo [$];
  bit          m_ovf = 1'b0;
  logic [31:0] exp_q;
  bit          exp_q_known;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    if (!FIFO_EN) return 32'h0000_0200;
    s = 32'(m_fifo.size());
    if (m_fifo.size() == DEPTH) s |= 32'h100;
    if (m_fifo.size() == 0)     s |= 32'h200;
    if (m_ovf)                  s |= 32'h400;
    return s;
  endfunction

  function automatic logic m_valid();
    return m_fifo.size() > 0;
  endfunction

  function automatic logic [31:0] m_head();
    return (m_fifo.size() > 0) ? m_fifo[0] : 32'h0;
  endfunction

  // One bus cycle: drive at negedge, advance the model, sample 1ns after posedge.
  task automatic step(input logic [11:0] a, input logic [31:0] d, input logic w, input logic r);
    bit pop;
    bit push;
    @(negedge clock);
    address_dmem = a; data = d; wren = w; tx_ready = r;
    exp_q_known = 1'b1;
    if (int'(a) < (1 << RAM_AW)) begin
      if (m_ram.exists(int'(a))) exp_q = m_ram[int'(a)];
      else begin exp_q = '0; exp_q_known = 1'b0; end
    end else if (a == 12'hFF0) exp_q = m_cycle + 32'd1;
    else if (a == 12'hFF2)     exp_q = m_status();
    else                       exp_q = '0;
    pop  = FIFO_EN && m_fifo.size() > 0 && r;
    push = FIFO_EN && w && a == 12'hFF1;
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
      else m_ovf = 1'b1;
    end
    if (FIFO_EN && w && a == 12'hFF2 && d[10]) m_ovf = 1'b0;
    m_cycle = (w && a == 12'hFF0) ? d : m_cycle + 32'd1;
    if (w && int'(a) < (1 << RAM_AW)) m_ram[int'(a)] = d;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    vectors++; if (q_dmem !== 32'h0) begin miscompares++; $display("FAIL reset_q: got %h expected %h", q_dmem, 32'h0); end
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    vectors++; if (tx_data !== 32'h0) begin miscompares++; $display("FAIL reset_tx_data: got %h expected 0", tx_data); end
    vectors++; if (fifo_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", fifo_overflow); end
    @(negedge clock);
    reset = 1'b1;
    m_cycle = '0; m_fifo.delete(); m_ovf = 1'b0;
    @(posedge clock);
    #1;
    m_cycle = m_cycle + 32'd1;
    step(12'hFF0, 32'h0, 1'b0, 1'b0);
    vectors++; if (q_dmem !== exp_q) begin miscompares++; $display("FAIL cycle_after_reset: got %h expected %h", q_dmem, exp_q); end
  endtask

  task automatic test_ram();
    logic [11:0] a;
    step(12'h005, 32'hDEADBEEF, 1'b1, 1'b0);
    step(12'h005, 32'h0, 1'b0, 1'b0);
    vectors++; if (q_dmem !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ram_rd_005: got %h expected %h", q_dmem, 32'hDEADBEEF); end
    step(12'h7FF, 32'h0, 1'b0, 1'b0);
    vectors++; if (q_dmem !== 32'h0) begin miscompares++; $display("FAIL rd_7ff: got %h expected 0", q_dmem); end
    // same-edge read of a written word returns the old contents
    step(12'h005, 32'h0BADF00D, 1'b1, 1'b0);
    vectors++; if (q_dmem !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ram_rdw_old: got %h expected %h", q_dmem, 32'hDEADBEEF); end
    step(12'h005, 32'hDEADBEEF, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) begin
      a = 12'($urandom_range(0, (1 << RAM_AW) - 1));
      if (a == 12'h005) a = 12'h006;
      step(a, $urandom, 1'b1, 1'b0);
      step(a, 32'h0, 1'b0, 1'b0);
      vectors++; if (q_dmem !== exp_q) begin miscompares++; $display("FAIL ram_rand @%h: got %h expected %h", a, q_dmem, exp_q); end
    end
  endtask

  task automatic test_counter();
    step(12'hFF0, 32'hFFFFFFFE, 1'b1, 1'b0);
    step(12'hFF0, 32'h0, 1'b0, 1'b0);
    vectors++; if (q_dmem !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL cycle_ffffffff: got %h expected %h", q_dmem, 32'hFFFFFFFF); end
    step(12'hFF0, 32'h0, 1'b0, 1'b0);
    vectors++; if (q_dmem !== 32'h0) begin miscompares++; $display("FAIL cycle_wrap: got %h expected 0", q_dmem); end
    step(12'hFF0, 32'h0, 1'b0, 1'b0);
    vectors++; if (q_dmem !== exp_q) begin miscompares++; $display("FAIL cycle_incr: got %h expected %h", q_dmem, exp_q); end
  endtask

  task automatic test_fifo_overflow();
    bit seen5 = 1'b0;
    for (int i = 1; i <= 5; i++) step(12'hFF1, 32'(i), 1'b1, 1'b0);
    step(12'hFF2, 32'h0, 1'b0, 1'b0);
    vectors++; if (q_dmem !== (FIFO_EN ? 32'h504 : 32'h200)) begin miscompares++; $display("FAIL status_full_ovf: got %h expected %h", q_dmem, FIFO_EN ? 32'h504 : 32'h200); end
    vectors++; if (q_dmem !== exp_q) begin miscompares++; $display("FAIL status_model: got %h expected %h", q_dmem, exp_q); end
    vectors++; if (fifo_overflow !== m_ovf) begin miscompares++; $display("FAIL overflow_flag: got %b expected %b", fifo_overflow, m_ovf); end
    vectors++; if (tx_data !== m_head()) begin miscompares++; $display("FAIL held_head: got %h expected %h", tx_data, m_head()); end
    for (int i = 0; i < 6; i++) begin
      step(12'h800, 32'h0, 1'b0, 1'b1);
      if (tx_valid && tx_data == 32'd5) seen5 = 1'b1;
      vectors++; if (tx_valid !== m_valid()) begin miscompares++; $display("FAIL drain_valid[%0d]: got %b expected %b", i, tx_valid, m_valid()); end
      vectors++; if (tx_data !== m_head()) begin miscompares++; $display("FAIL drain_data[%0d]: got %h expected %h", i, tx_data, m_head()); end
    end
    vectors++; if (seen5 !== 1'b0) begin miscompares++; $display("FAIL dropped_word_seen: got %b expected 0", seen5); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] last = '0;
    step(12'hFF2, 32'h400, 1'b1, 1'b0);
    vectors++; if (fifo_overflow !== 1'b0) begin miscompares++; $display("FAIL overflow_clear: got %b expected 0", fifo_overflow); end
    for (int i = 0; i < 4; i++) step(12'hFF1, 32'h20 + 32'(i), 1'b1, 1'b0);
    step(12'hFF1, 32'd9, 1'b1, 1'b1);
    step(12'hFF2, 32'h0, 1'b0, 1'b0);
    vectors++; if (q_dmem !== (FIFO_EN ? 32'h104 : 32'h200)) begin miscompares++; $display("FAIL pushpop_status: got %h expected %h", q_dmem, FIFO_EN ? 32'h104 : 32'h200); end
    vectors++; if (fifo_overflow !== 1'b0) begin miscompares++; $display("FAIL pushpop_overflow: got %b expected 0", fifo_overflow); end
    for (int i = 0; i < 6; i++) begin
      if (tx_valid) last = tx_data;
      step(12'h800, 32'h0, 1'b0, 1'b1);
      vectors++; if (tx_data !== m_head()) begin miscompares++; $display("FAIL pushpop_drain[%0d]: got %h expected %h", i, tx_data, m_head()); end
    end
    vectors++; if (last !== (FIFO_EN ? 32'd9 : 32'd0)) begin miscompares++; $display("FAIL pushpop_last: got %h expected %h", last, FIFO_EN ? 32'd9 : 32'd0); end
  endtask

  task automatic test_reset_midstream();
    step(12'h010, 32'h12345678, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(12'hFF1, 32'hA1 + 32'(i), 1'b1, 1'b0);
    step(12'hFF0, 32'h0, 1'b0, 1'b0);
    wren = 1'b0;
    reset = 1'b0;
    #1;
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b expected 0", tx_valid); end
    vectors++; if (q_dmem !== 32'h0) begin miscompares++; $display("FAIL midrst_q: got %h expected 0", q_dmem); end
    vectors++; if (tx_data !== 32'h0) begin miscompares++; $display("FAIL midrst_tx_data: got %h expected 0", tx_data); end
    @(negedge clock);
    reset = 1'b1;
    m_cycle = '0; m_fifo.delete(); m_ovf = 1'b0;
    @(posedge clock);
    #1;
    m_cycle = m_cycle + 32'd1;
    step(12'hFF2, 32'h0, 1'b0, 1'b0);
    vectors++; if (q_dmem !== 32'h200) begin miscompares++; $display("FAIL midrst_status: got %h expected %h", q_dmem, 32'h200); end
    step(12'h005, 32'h0, 1'b0, 1'b0);
    vectors++; if (q_dmem !== 32'hDEADBEEF) begin miscompares++; $display("FAIL midrst_ram5: got %h expected %h", q_dmem, 32'hDEADBEEF); end
    step(12'h010, 32'h0, 1'b0, 1'b0);
    vectors++; if (q_dmem !== 32'h12345678) begin miscompares++; $display("FAIL midrst_ram10: got %h expected %h", q_dmem, 32'h12345678); end
    step(12'hFF0, 32'h0, 1'b0, 1'b0);
    vectors++; if (q_dmem !== exp_q) begin miscompares++; $display("FAIL midrst_cycle: got %h expected %h", q_dmem, exp_q); end
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic        w;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: a = 12'($urandom_range(0, (1 << RAM_AW) - 1));
        3:       a = 12'hFF0;
        4, 5:    a = 12'hFF1;
        6:       a = 12'hFF2;
        default: a = 12'($urandom_range(12'h100, 12'hFEF));
      endcase
      w = ($urandom_range(0, 3) != 0);
      if (a == 12'hFF0 && $urandom_range(0, 3) != 0) w = 1'b0;
      step(a, $urandom, w, 1'($urandom_range(0, 1)));
      if (exp_q_known && !(w && a == 12'hFF0)) begin
        vectors++; if (q_dmem !== exp_q) begin miscompares++; $display("FAIL rand_q[%0d] @%h: got %h expected %h", i, a, q_dmem, exp_q); end
      end
      vectors++; if (tx_valid !== m_valid()) begin miscompares++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, tx_valid, m_valid()); end
      vectors++; if (tx_data !== m_head()) begin miscompares++; $display("FAIL rand_data[%0d]: got %h expected %h", i, tx_data, m_head()); end
      vectors++; if (fifo_overflow !== m_ovf) begin miscompares++; $display("FAIL rand_ovf[%0d]: got %b expected %b", i, fifo_overflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_counter();
    test_fifo_overflow();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
